pong_game_engine: RTL and testbench
===================================

// Module: pong_game_engine
// PURPOSE
//   Parametrised Pong game core: paddle motion, ball physics, 5-zone paddle deflection,
//   scoring, serve delay and game-over detection, all sequenced by one FSM. Sits between
//   the rotary-encoder decoders / ball-tick divider and the pixel colour mapper, which
//   reads the registered positions. Frame size, paddle geometry, speeds and win score are generics.
// PARAMETERS
//   FRAME_W      640  playfield width in pixels
//   FRAME_H      480  playfield height in pixels
//   PAD_W        8    paddle width
//   PAD_H        80   paddle height; must be a multiple of 5 (zone size = PAD_H/5)
//   P1_X         16   left paddle x; P2_X = FRAME_W-P1_X-PAD_W
//   BALL_SZ      8    ball edge length (square ball)
//   PAD_SPEED    8    pixels per up/down pulse
//   SCORE_W      4    score counter width
//   WIN_SCORE    9    points to win; must be < 2**SCORE_W
//   SERVE_TICKS  60   ticks the ball rests at centre after a point
// PORTS
//   CLOCK_25     in   1        system clock
//   reset_n      in   1        asynchronous active-low reset
//   tick         in   1        one-cycle ball-step strobe, synchronous to CLOCK_25
//   pause_req    in   1        level, active high
//   resume_req   in   1        level, active high
//   p1_up/p1_down in 1 each    one-cycle move pulses, player 1
//   p2_up/p2_down in 1 each    one-cycle move pulses, player 2
//   ball_x/ball_y out  12 each  ball top-left corner
//   p1_y/p2_y    out  12 each  paddle top edge
//   score_1/score_2 out SCORE_W points
//   state        out  3        FSM state (pong_pkg encoding)
//   winner       out  2        0 none, 1 player 1, 2 player 2
//   point_pulse  out  1        one-cycle pulse when a point is scored
// BEHAVIOUR
//   - Reset: state=IDLE; ball centred ((FRAME_W-BALL_SZ)/2,(FRAME_H-BALL_SZ)/2); paddles
//     (FRAME_H-PAD_H)/2; scores 0; winner 0; point_pulse 0; dir right, vx=4, vy=0.
//   - FSM: IDLE -resume-> PLAY; PLAY -pause-> PAUSED; PAUSED -resume-> PLAY;
//     PLAY -miss-> POINT; POINT -SERVE_TICKS ticks-> PLAY; POINT with score=WIN_SCORE -> OVER;
//     OVER -resume-> clear scores/winner, enter POINT. pause+resume same cycle: resume wins.
//   - Paddles: move only in PLAY/POINT, any cycle (not tick-gated). up&down same cycle: no move.
//     Clamp to [1, FRAME_H-PAD_H-1]; update visible next cycle.
//   - Ball: steps only on tick in PLAY; pause on tick cycle suppresses the step. x +/- vx, y +/- vy.
//   - Walls: if next y <= 1 -> y=1, dir down; if next y >= FRAME_H-BALL_SZ-1 -> clamp, dir up.
//   - Paddle check when moving toward paddle and ball face crosses paddle face:
//     off = ball_y+BALL_SZ/2-pad_y; off in [0,PAD_H): zone=off/(PAD_H/5);
//     zone 0:(vx2,vy2,up) 1:(3,1,up) 2:(4,0,dir unchanged) 3:(3,1,down) 4:(2,2,down);
//     x snapped flush to paddle face, x direction reversed, same tick.
//     off outside range (unsigned wrap = miss): opponent score +1, point_pulse, -> POINT.
//   - Paddle wins over wall if both hit on one tick (x and y updates are independent).
//   - POINT: ball recentred immediately; serve dir toward the player who conceded, vx=4 vy=0.
//   - Scores saturate at WIN_SCORE; winner set the cycle the winning score registers.
//   - Ball/score arithmetic 13-bit internally; no x/y wrap permitted.
//   - reset_n asserted mid-rally: all registers return to reset values asynchronously.
// STRUCTURE
//   - pong_pkg: state encoding (IDLE,PLAY,PAUSED,POINT,OVER), zone velocity/dir table.
//   - Sub-module pong_paddle (x2): pulse-driven clamped y register, shared PAD_* params.
//   - Top: FSM, ball datapath, collision/zone compare, serve counter, score counters.
// TESTING
//   - Reset then resume: state PLAY, after 10 ticks ball_x=316+40=356, ball_y=236.
//   - p1_up x40 from y=200: p1_y clamps at 1; p1_up&p1_down together: p1_y unchanged.
//   - Ball centre at paddle off=40 (zone 2): x flips, vx=4,vy=0; off=5: vx=2,vy=2 up.
//   - Ball passes P1 with off=90: score_2=1, point_pulse 1 cycle, ball centred, 60 ticks to PLAY.
//   - score_1=8 then P2 miss: score_1=9, winner=1, state OVER; resume -> scores 0, POINT.
//   - pause_req on tick cycle: ball unchanged; pause+resume together in PLAY: stays PLAY.

Source files
------------

// File: rtl/pong_pkg.sv
// Shared Pong types: FSM state encoding and the paddle-zone deflection table.
package pong_pkg;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_PLAY   = 3'd1,
      ST_PAUSED = 3'd2,
      ST_POINT  = 3'd3,
      ST_OVER   = 3'd4
   } state_t;

   // Ball velocity after striking one of the five paddle zones
   typedef struct packed {
      logic [2:0] vx;
      logic [2:0] vy;
      logic       keep_dir;   // centre zone leaves vertical direction alone
      logic       down;       // new vertical direction when not kept
   } zone_vel_t;

   localparam logic [2:0] SERVE_VX = 3'd4;

   // Outer zones deflect steeply, centre zone returns flat and fast
   function automatic zone_vel_t zone_vel(input logic [2:0] zone);
      zone_vel_t v;
      case (zone)
         3'd0:    v = '{vx: 3'd2, vy: 3'd2, keep_dir: 1'b0, down: 1'b0};
         3'd1:    v = '{vx: 3'd3, vy: 3'd1, keep_dir: 1'b0, down: 1'b0};
         3'd3:    v = '{vx: 3'd3, vy: 3'd1, keep_dir: 1'b0, down: 1'b1};
         3'd4:    v = '{vx: 3'd2, vy: 3'd2, keep_dir: 1'b0, down: 1'b1};
         default: v = '{vx: 3'd4, vy: 3'd0, keep_dir: 1'b1, down: 1'b0};
      endcase
      return v;
   endfunction

endpackage

// File: rtl/pong_paddle.sv
// One paddle: pulse-driven vertical position, clamped inside the playfield.
module pong_paddle #(
   parameter int FRAME_H   = 480,
   parameter int PAD_H     = 80,
   parameter int PAD_SPEED = 8
) (
   input  logic        CLOCK_25,
   input  logic        reset_n,
   input  logic        en,
   input  logic        up,
   input  logic        down,
   output logic [11:0] y
);

   localparam int               Y_MAX   = FRAME_H - PAD_H - 1;
   localparam logic signed [12:0] SPD   = 13'(PAD_SPEED);
   localparam logic signed [12:0] MIN_S = 13'sd1;
   localparam logic signed [12:0] MAX_S = 13'(Y_MAX);
   localparam logic [11:0]        Y_RST = 12'((FRAME_H - PAD_H) / 2);

   logic signed [12:0] y_up;
   logic signed [12:0] y_dn;
   logic [11:0]        y_nxt;

   // One speed step per pulse; opposing pulses cancel; clamp at both edges
   always_comb begin
      y_nxt = y;
      y_up  = $signed({1'b0, y}) - SPD;
      y_dn  = $signed({1'b0, y}) + SPD;
      if (en && up && !down)
         y_nxt = (y_up < MIN_S) ? MIN_S[11:0] : y_up[11:0];
      else if (en && down && !up)
         y_nxt = (y_dn > MAX_S) ? MAX_S[11:0] : y_dn[11:0];
   end

   // Position register, centred on reset
   always_ff @(posedge CLOCK_25 or negedge reset_n) begin
      if (!reset_n) y <= Y_RST;
      else          y <= y_nxt;
   end

endmodule

// File: rtl/pong_game_engine.sv
// Pong core: game FSM, ball physics with zoned paddle deflection, scoring and serve delay.
module pong_game_engine
   import pong_pkg::*;
#(
   parameter int FRAME_W     = 640,
   parameter int FRAME_H     = 480,
   parameter int PAD_W       = 8,
   parameter int PAD_H       = 80,
   parameter int P1_X        = 16,
   parameter int BALL_SZ     = 8,
   parameter int PAD_SPEED   = 8,
   parameter int SCORE_W     = 4,
   parameter int WIN_SCORE   = 9,
   parameter int SERVE_TICKS = 60
) (
   input  logic               CLOCK_25,
   input  logic               reset_n,
   input  logic               tick,
   input  logic               pause_req,
   input  logic               resume_req,
   input  logic               p1_up,
   input  logic               p1_down,
   input  logic               p2_up,
   input  logic               p2_down,
   output logic [11:0]        ball_x,
   output logic [11:0]        ball_y,
   output logic [11:0]        p1_y,
   output logic [11:0]        p2_y,
   output logic [SCORE_W-1:0] score_1,
   output logic [SCORE_W-1:0] score_2,
   output logic [2:0]         state,
   output logic [1:0]         winner,
   output logic               point_pulse
);

   localparam int P2_X  = FRAME_W - P1_X - PAD_W;
   localparam int SRV_W = $clog2(SERVE_TICKS + 1);

   localparam logic signed [12:0] P1_FACE = 13'(P1_X + PAD_W);
   localparam logic signed [12:0] P2_FACE = 13'(P2_X);
   localparam logic signed [12:0] P2_SNAP = 13'(P2_X - BALL_SZ);
   localparam logic signed [12:0] BALL_S  = 13'(BALL_SZ);
   localparam logic signed [12:0] Y_MIN_S = 13'sd1;
   localparam logic signed [12:0] Y_MAX_S = 13'(FRAME_H - BALL_SZ - 1);
   localparam logic [12:0]        HALF_B  = 13'(BALL_SZ / 2);
   localparam logic [12:0]        PAD_H13 = 13'(PAD_H);
   localparam logic [12:0]        ZONE_H  = 13'(PAD_H / 5);
   localparam logic [11:0]        BX0     = 12'((FRAME_W - BALL_SZ) / 2);
   localparam logic [11:0]        BY0     = 12'((FRAME_H - BALL_SZ) / 2);
   localparam logic [SCORE_W-1:0] WIN     = SCORE_W'(WIN_SCORE);
   localparam logic [SCORE_W-1:0] WIN_M1  = SCORE_W'(WIN_SCORE - 1);
   localparam logic [SRV_W-1:0]   SRV_END = SRV_W'(SERVE_TICKS - 1);

   state_t             st, st_n;
   logic [SRV_W-1:0]   srv, srv_n;
   logic [2:0]         vx, vy, vx_n, vy_n;
   logic               dir_r, dir_d, dr_n, dd_n;
   logic [11:0]        bx_n, by_n;
   logic signed [12:0] bx, by, nx, ny;
   logic [12:0]        off1, off2;
   logic               cross1, cross2, hit1, hit2;
   logic               step, miss1, miss2, pad_en, win_reached;
   zone_vel_t          zv1, zv2;

   assign state       = st;
   assign pad_en      = (st == ST_PLAY) || (st == ST_POINT);
   assign step        = (st == ST_PLAY) && tick && (!pause_req || resume_req);
   assign win_reached = (score_1 == WIN) || (score_2 == WIN);

   pong_paddle #(.FRAME_H(FRAME_H), .PAD_H(PAD_H), .PAD_SPEED(PAD_SPEED)) u_pad1 (
      .CLOCK_25(CLOCK_25), .reset_n(reset_n), .en(pad_en),
      .up(p1_up), .down(p1_down), .y(p1_y)
   );

   pong_paddle #(.FRAME_H(FRAME_H), .PAD_H(PAD_H), .PAD_SPEED(PAD_SPEED)) u_pad2 (
      .CLOCK_25(CLOCK_25), .reset_n(reset_n), .en(pad_en),
      .up(p2_up), .down(p2_down), .y(p2_y)
   );

   // Candidate step plus face-crossing and zone lookup against the current paddles
   always_comb begin
      bx     = $signed({1'b0, ball_x});
      by     = $signed({1'b0, ball_y});
      nx     = dir_r ? bx + $signed({10'd0, vx}) : bx - $signed({10'd0, vx});
      ny     = dir_d ? by + $signed({10'd0, vy}) : by - $signed({10'd0, vy});
      cross1 = !dir_r && (bx >= P1_FACE) && (nx <= P1_FACE);
      cross2 = dir_r && (bx + BALL_S <= P2_FACE) && (nx + BALL_S >= P2_FACE);
      // unsigned wrap makes a ball above the paddle land far outside [0,PAD_H)
      off1   = {1'b0, ball_y} + HALF_B - {1'b0, p1_y};
      off2   = {1'b0, ball_y} + HALF_B - {1'b0, p2_y};
      hit1   = off1 < PAD_H13;
      hit2   = off2 < PAD_H13;
      zv1    = zone_vel(3'(off1 / ZONE_H));
      zv2    = zone_vel(3'(off2 / ZONE_H));
   end

   // Ball next state: y handles walls, x handles paddles; a paddle strike owns the y direction
   always_comb begin
      bx_n  = ball_x;
      by_n  = ball_y;
      vx_n  = vx;
      vy_n  = vy;
      dr_n  = dir_r;
      dd_n  = dir_d;
      miss1 = 1'b0;
      miss2 = 1'b0;
      if (step) begin
         bx_n = nx[11:0];
         if (ny <= Y_MIN_S) begin
            by_n = Y_MIN_S[11:0];
            dd_n = 1'b1;
         end else if (ny >= Y_MAX_S) begin
            by_n = Y_MAX_S[11:0];
            dd_n = 1'b0;
         end else begin
            by_n = ny[11:0];
         end
         if (cross1) begin
            if (hit1) begin
               bx_n = P1_FACE[11:0];
               dr_n = 1'b1;
               vx_n = zv1.vx;
               vy_n = zv1.vy;
               if (!zv1.keep_dir) dd_n = zv1.down;
            end else begin
               miss1 = 1'b1;
            end
         end else if (cross2) begin
            if (hit2) begin
               bx_n = P2_SNAP[11:0];
               dr_n = 1'b0;
               vx_n = zv2.vx;
               vy_n = zv2.vy;
               if (!zv2.keep_dir) dd_n = zv2.down;
            end else begin
               miss2 = 1'b1;
            end
         end
         // recentre at once and serve toward whoever conceded
         if (miss1 || miss2) begin
            bx_n = BX0;
            by_n = BY0;
            vx_n = SERVE_VX;
            vy_n = 3'd0;
            dr_n = miss2;
         end
      end
   end

   // Ball position and velocity registers
   always_ff @(posedge CLOCK_25 or negedge reset_n) begin
      if (!reset_n) begin
         ball_x <= BX0;
         ball_y <= BY0;
         vx     <= SERVE_VX;
         vy     <= 3'd0;
         dir_r  <= 1'b1;
         dir_d  <= 1'b1;
      end else begin
         ball_x <= bx_n;
         ball_y <= by_n;
         vx     <= vx_n;
         vy     <= vy_n;
         dir_r  <= dr_n;
         dir_d  <= dd_n;
      end
   end

   // Saturating scores, winner flag (set with the winning point) and point strobe
   always_ff @(posedge CLOCK_25 or negedge reset_n) begin
      if (!reset_n) begin
         score_1     <= '0;
         score_2     <= '0;
         winner      <= 2'd0;
         point_pulse <= 1'b0;
      end else begin
         point_pulse <= miss1 | miss2;
         if (st == ST_OVER && resume_req) begin
            score_1 <= '0;
            score_2 <= '0;
            winner  <= 2'd0;
         end else begin
            if (miss2 && score_1 != WIN) begin
               score_1 <= score_1 + 1'b1;
               if (score_1 == WIN_M1) winner <= 2'd1;
            end
            if (miss1 && score_2 != WIN) begin
               score_2 <= score_2 + 1'b1;
               if (score_2 == WIN_M1) winner <= 2'd2;
            end
         end
      end
   end

   // FSM state and serve-delay counter registers
   always_ff @(posedge CLOCK_25 or negedge reset_n) begin
      if (!reset_n) begin
         st  <= ST_IDLE;
         srv <= '0;
      end else begin
         st  <= st_n;
         srv <= srv_n;
      end
   end

   // Next state: resume beats pause; a finished game beats serving
   always_comb begin
      st_n  = st;
      srv_n = '0;
      case (st)
         ST_IDLE:   if (resume_req) st_n = ST_PLAY;
         ST_PLAY: begin
            if (miss1 || miss2)              st_n = ST_POINT;
            else if (pause_req && !resume_req) st_n = ST_PAUSED;
         end
         ST_PAUSED: if (resume_req) st_n = ST_PLAY;
         ST_POINT: begin
            if (win_reached) begin
               st_n = ST_OVER;
            end else if (tick) begin
               if (srv == SRV_END) st_n = ST_PLAY;
               else                srv_n = srv + 1'b1;
            end else begin
               srv_n = srv;
            end
         end
         ST_OVER:   if (resume_req) st_n = ST_POINT;
         default:   st_n = ST_IDLE;
      endcase
   end

endmodule

// File: tb/tb_pong_game_engine.sv
// Bench for pong_game_engine: directed scenarios plus random play against a reference model.
module tb_pong_game_engine;

   localparam int S_IDLE = 0, S_PLAY = 1, S_PAUSED = 2, S_POINT = 3, S_OVER = 4;
   localparam int P1F = 24, P2X = 616, BALL = 8, PADH = 80, YMAX = 471, PMAX = 399;

   logic        CLOCK_25 = 1'b0;
   logic        reset_n = 1'b1;
   logic        tick = 0, pause_req = 0, resume_req = 0;
   logic        p1_up = 0, p1_down = 0, p2_up = 0, p2_down = 0;
   logic [11:0] ball_x, ball_y, p1_y, p2_y;
   logic [3:0]  score_1, score_2;
   logic [2:0]  state;
   logic [1:0]  winner;
   logic        point_pulse;
   logic [61:0] dut_vec;

   int n_tests = 0;
   int n_fail  = 0;

   int m_st, m_bx, m_by, m_vx, m_vy, m_dr, m_dd, m_p1, m_p2, m_s1, m_s2, m_win, m_srv;
   bit m_pp;
   int zvx[5]  = '{2, 3, 4, 3, 2};
   int zvy[5]  = '{2, 1, 0, 1, 2};
   int zdir[5] = '{0, 0, -1, 1, 1};   // 0 up, 1 down, -1 keep

   pong_game_engine dut (
      .CLOCK_25(CLOCK_25), .reset_n(reset_n), .tick(tick),
      .pause_req(pause_req), .resume_req(resume_req),
      .p1_up(p1_up), .p1_down(p1_down), .p2_up(p2_up), .p2_down(p2_down),
      .ball_x(ball_x), .ball_y(ball_y), .p1_y(p1_y), .p2_y(p2_y),
      .score_1(score_1), .score_2(score_2), .state(state),
      .winner(winner), .point_pulse(point_pulse)
   );

   always #5 CLOCK_25 = ~CLOCK_25;

   assign dut_vec = {ball_x, ball_y, p1_y, p2_y, score_1, score_2, state, winner, point_pulse};

   function automatic logic [61:0] model_vec();
      return {12'(m_bx), 12'(m_by), 12'(m_p1), 12'(m_p2), 4'(m_s1), 4'(m_s2),
              3'(m_st), 2'(m_win), m_pp};
   endfunction

   task automatic m_reset();
      m_st = S_IDLE; m_bx = 316; m_by = 236; m_vx = 4; m_vy = 0; m_dr = 1; m_dd = 1;
      m_p1 = 200; m_p2 = 200; m_s1 = 0; m_s2 = 0; m_win = 0; m_srv = 0; m_pp = 0;
   endtask

   function automatic int pad_move(int y, logic up, logic dn);
      if (up && !dn) return (y - 8 < 1) ? 1 : y - 8;
      if (dn && !up) return (y + 8 > PMAX) ? PMAX : y + 8;
      return y;
   endfunction

   // Game rules applied once per clock edge to the inputs present at that edge
   task automatic model_update();
      int nx, ny, ndd, off, z, o_st, o_s1, o_s2;
      bit stp, miss1, miss2;
      o_st = m_st; o_s1 = m_s1; o_s2 = m_s2;
      miss1 = 0; miss2 = 0;
      stp = (m_st == S_PLAY) && tick && (!pause_req || resume_req);
      if (stp) begin
         nx  = m_dr ? m_bx + m_vx : m_bx - m_vx;
         ny  = m_dd ? m_by + m_vy : m_by - m_vy;
         ndd = m_dd;
         if (ny <= 1) begin ny = 1; ndd = 1; end
         else if (ny >= YMAX) begin ny = YMAX; ndd = 0; end
         if (m_dr == 0 && m_bx >= P1F && nx <= P1F) begin
            off = m_by + BALL / 2 - m_p1;
            if (off >= 0 && off < PADH) begin
               z = off / (PADH / 5); nx = P1F; m_dr = 1; m_vx = zvx[z]; m_vy = zvy[z];
               if (zdir[z] >= 0) ndd = zdir[z];
            end else miss1 = 1;
         end else if (m_dr == 1 && m_bx + BALL <= P2X && nx + BALL >= P2X) begin
            off = m_by + BALL / 2 - m_p2;
            if (off >= 0 && off < PADH) begin
               z = off / (PADH / 5); nx = P2X - BALL; m_dr = 0; m_vx = zvx[z]; m_vy = zvy[z];
               if (zdir[z] >= 0) ndd = zdir[z];
            end else miss2 = 1;
         end
         m_bx = nx; m_by = ny; m_dd = ndd;
         if (miss1 || miss2) begin
            m_bx = 316; m_by = 236; m_vx = 4; m_vy = 0; m_dr = miss2 ? 1 : 0;
         end
      end
      if (o_st == S_PLAY || o_st == S_POINT) begin
         m_p1 = pad_move(m_p1, p1_up, p1_down);
         m_p2 = pad_move(m_p2, p2_up, p2_down);
      end
      if (miss2) begin m_s1 = (m_s1 + 1 > 9) ? 9 : m_s1 + 1; if (m_s1 == 9) m_win = 1; end
      if (miss1) begin m_s2 = (m_s2 + 1 > 9) ? 9 : m_s2 + 1; if (m_s2 == 9) m_win = 2; end
      m_pp = miss1 || miss2;
      case (o_st)
         S_IDLE:   if (resume_req) m_st = S_PLAY;
         S_PLAY: begin
            if (miss1 || miss2) begin m_st = S_POINT; m_srv = 0; end
            else if (pause_req && !resume_req) m_st = S_PAUSED;
         end
         S_PAUSED: if (resume_req) m_st = S_PLAY;
         S_POINT: begin
            if (o_s1 == 9 || o_s2 == 9) m_st = S_OVER;
            else if (tick) begin
               m_srv++;
               if (m_srv == 60) begin m_st = S_PLAY; m_srv = 0; end
            end
         end
         S_OVER: if (resume_req) begin
            m_st = S_POINT; m_s1 = 0; m_s2 = 0; m_win = 0; m_srv = 0;
         end
         default: ;
      endcase
   endtask

   task automatic clear_inputs();
      tick = 0; pause_req = 0; resume_req = 0;
      p1_up = 0; p1_down = 0; p2_up = 0; p2_down = 0;
   endtask

   task automatic step();
      @(posedge CLOCK_25);
      model_update();
      #1;
      clear_inputs();
   endtask

   task automatic do_reset();
      @(negedge CLOCK_25);
      clear_inputs();
      reset_n = 0;
      m_reset();
      @(negedge CLOCK_25);
      reset_n = 1;
   endtask

   task automatic test_reset();
      do_reset();
      n_tests++;
      if (dut_vec !== model_vec()) begin
         n_fail++; $display("FAIL reset_model got=%h exp=%h", dut_vec, model_vec());
      end
      n_tests++;
      if ({ball_x, ball_y, p1_y, p2_y} !== {12'd316, 12'd236, 12'd200, 12'd200}) begin
         n_fail++; $display("FAIL reset_pos got=%0d,%0d,%0d,%0d exp=316,236,200,200", ball_x, ball_y, p1_y, p2_y);
      end
      n_tests++;
      if ({state, winner, score_1, score_2, point_pulse} !== 14'd0) begin
         n_fail++; $display("FAIL reset_flags got st=%0d w=%0d s=%0d/%0d pp=%0b exp all 0", state, winner, score_1, score_2, point_pulse);
      end
   endtask

   task automatic test_serve_motion();
      do_reset();
      resume_req = 1; step();
      n_tests++;
      if (state !== 3'd1) begin n_fail++; $display("FAIL idle_resume got=%0d exp=1", state); end
      repeat (10) begin
         tick = 1; step();
         n_tests++;
         if (dut_vec !== model_vec()) begin
            n_fail++; $display("FAIL serve_model got=%h exp=%h", dut_vec, model_vec());
         end
      end
      n_tests++;
      if (ball_x !== 12'd356 || ball_y !== 12'd236) begin
         n_fail++; $display("FAIL serve_10_ticks got=%0d,%0d exp=356,236", ball_x, ball_y);
      end
   endtask

   task automatic test_paddle_clamp();
      do_reset();
      p1_up = 1; step();
      n_tests++;
      if (p1_y !== 12'd200) begin n_fail++; $display("FAIL paddle_idle got=%0d exp=200", p1_y); end
      resume_req = 1; step();
      repeat (40) begin p1_up = 1; step(); end
      n_tests++;
      if (p1_y !== 12'd1) begin n_fail++; $display("FAIL paddle_top_clamp got=%0d exp=1", p1_y); end
      repeat (3) begin p1_down = 1; step(); end
      p1_up = 1; p1_down = 1; step();
      n_tests++;
      if (p1_y !== 12'd25) begin n_fail++; $display("FAIL paddle_up_down got=%0d exp=25", p1_y); end
      repeat (60) begin p2_down = 1; step(); end
      n_tests++;
      if (p2_y !== 12'd399 || p1_y !== 12'd25) begin
         n_fail++; $display("FAIL paddle_bot_clamp got=%0d,%0d exp=399,25", p2_y, p1_y);
      end
      pause_req = 1; step();
      p2_up = 1; step();
      n_tests++;
      if (p2_y !== 12'd399 || dut_vec !== model_vec()) begin
         n_fail++; $display("FAIL paddle_paused got=%h exp=%h", dut_vec, model_vec());
      end
   endtask

   task automatic test_zone_bounce();
      do_reset();
      resume_req = 1; step();
      for (int i = 1; i <= 219; i++) begin
         tick = 1; step();
         n_tests++;
         if (dut_vec !== model_vec()) begin
            n_fail++; $display("FAIL zone2_model tick=%0d got=%h exp=%h", i, dut_vec, model_vec());
         end
         if (i == 73) begin
            n_tests++;
            if (ball_x !== 12'd608) begin n_fail++; $display("FAIL zone2_p2_snap got=%0d exp=608", ball_x); end
         end
      end
      n_tests++;
      if (ball_x !== 12'd24) begin n_fail++; $display("FAIL zone2_p1_snap got=%0d exp=24", ball_x); end
      tick = 1; step();
      n_tests++;
      if (ball_x !== 12'd28 || ball_y !== 12'd236) begin
         n_fail++; $display("FAIL zone2_return got=%0d,%0d exp=28,236", ball_x, ball_y);
      end
      // paddle lowered so the ball centre sits 8 px into zone 0
      do_reset();
      resume_req = 1; step();
      repeat (4) begin p1_down = 1; step(); end
      repeat (219) begin tick = 1; step(); end
      n_tests++;
      if (ball_x !== 12'd24 || ball_y !== 12'd236) begin
         n_fail++; $display("FAIL zone0_hit got=%0d,%0d exp=24,236", ball_x, ball_y);
      end
      tick = 1; step();
      n_tests++;
      if (ball_x !== 12'd26 || ball_y !== 12'd234 || dut_vec !== model_vec()) begin
         n_fail++; $display("FAIL zone0_deflect got=%0d,%0d exp=26,234", ball_x, ball_y);
      end
   endtask

   task automatic test_miss_point();
      do_reset();
      resume_req = 1; step();
      repeat (7) begin p1_up = 1; step(); end
      repeat (219) begin tick = 1; step(); end
      n_tests++;
      if (score_2 !== 4'd1 || point_pulse !== 1'b1 || state !== 3'd3 ||
          ball_x !== 12'd316 || ball_y !== 12'd236) begin
         n_fail++; $display("FAIL miss_score got s2=%0d pp=%0b st=%0d ball=%0d,%0d exp 1,1,3,316,236",
                            score_2, point_pulse, state, ball_x, ball_y);
      end
      step();
      n_tests++;
      if (point_pulse !== 1'b0) begin n_fail++; $display("FAIL miss_pulse_width got=%0b exp=0", point_pulse); end
      repeat (59) begin tick = 1; step(); end
      n_tests++;
      if (state !== 3'd3) begin n_fail++; $display("FAIL serve_hold got=%0d exp=3", state); end
      tick = 1; step();
      n_tests++;
      if (state !== 3'd1) begin n_fail++; $display("FAIL serve_release got=%0d exp=1", state); end
      tick = 1; step();
      n_tests++;
      if (ball_x !== 12'd312 || dut_vec !== model_vec()) begin
         n_fail++; $display("FAIL serve_dir got=%0d exp=312", ball_x);
      end
   endtask

   task automatic test_game_over();
      int n;
      do_reset();
      resume_req = 1; step();
      repeat (30) begin p2_up = 1; step(); end
      n = 0;
      while (m_win == 0 && n < 3000) begin
         tick = 1; step(); n++;
         n_tests++;
         if (dut_vec !== model_vec()) begin
            n_fail++; $display("FAIL game_model tick=%0d got=%h exp=%h", n, dut_vec, model_vec());
         end
      end
      n_tests++;
      if (n >= 3000) begin n_fail++; $display("FAIL game_timeout got=%0d ticks exp<3000", n); end
      n_tests++;
      if (score_1 !== 4'd9 || winner !== 2'd1 || state !== 3'd3) begin
         n_fail++; $display("FAIL game_win got s1=%0d w=%0d st=%0d exp 9,1,3", score_1, winner, state);
      end
      step();
      n_tests++;
      if (state !== 3'd4) begin n_fail++; $display("FAIL game_over_state got=%0d exp=4", state); end
      resume_req = 1; step();
      n_tests++;
      if ({score_1, score_2, winner, state} !== {4'd0, 4'd0, 2'd0, 3'd3}) begin
         n_fail++; $display("FAIL game_restart got s=%0d/%0d w=%0d st=%0d exp 0,0,0,3", score_1, score_2, winner, state);
      end
   endtask

   task automatic test_pause();
      do_reset();
      resume_req = 1; step();
      repeat (5) begin tick = 1; step(); end
      pause_req = 1; tick = 1; step();
      n_tests++;
      if (ball_x !== 12'd336 || state !== 3'd2) begin
         n_fail++; $display("FAIL pause_on_tick got=%0d st=%0d exp=336 st=2", ball_x, state);
      end
      tick = 1; step();
      n_tests++;
      if (ball_x !== 12'd336) begin n_fail++; $display("FAIL paused_tick got=%0d exp=336", ball_x); end
      resume_req = 1; step();
      pause_req = 1; resume_req = 1; tick = 1; step();
      n_tests++;
      if (state !== 3'd1 || ball_x !== 12'd340) begin
         n_fail++; $display("FAIL pause_resume_same got st=%0d x=%0d exp st=1 x=340", state, ball_x);
      end
   endtask

   task automatic test_async_reset();
      do_reset();
      resume_req = 1; step();
      repeat (20) begin tick = 1; p1_down = 1; step(); end
      #2;
      reset_n = 0;
      m_reset();
      #1;
      n_tests++;
      if (dut_vec !== model_vec() || ball_x !== 12'd316) begin
         n_fail++; $display("FAIL async_reset got=%h exp=%h", dut_vec, model_vec());
      end
      @(negedge CLOCK_25);
      reset_n = 1;
   endtask

   task automatic test_random();
      do_reset();
      for (int i = 0; i < 4000; i++) begin
         tick       = 1'($urandom_range(0, 1));
         p1_up      = ($urandom_range(0, 3) == 0);
         p1_down    = ($urandom_range(0, 3) == 0);
         p2_up      = ($urandom_range(0, 3) == 0);
         p2_down    = ($urandom_range(0, 3) == 0);
         pause_req  = ($urandom_range(0, 39) == 0);
         resume_req = ($urandom_range(0, 19) == 0);
         step();
         n_tests++;
         if (dut_vec !== model_vec()) begin
            n_fail++; $display("FAIL random_model cyc=%0d got=%h exp=%h", i, dut_vec, model_vec());
         end
      end
   endtask

   initial begin
      m_reset();
      test_reset();
      test_serve_motion();
      test_paddle_clamp();
      test_zone_bounce();
      test_miss_point();
      test_game_over();
      test_pause();
      test_async_reset();
      test_random();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog expired");
   end

endmodule
